// File: rtl/lamp_handball_ctrl.sv
// lamp_handball_ctrl: two-player "lamp handball" game controller.
// A ball of light bounces along a row of five lamps. The left player guards
// lamp[4] (btn_l), the right player guards lamp[0] (btn_r). Pressing while
// the ball sits on your end lamp returns it. Missing the ball, or pressing
// early, hands the point to the opponent. First to WIN_SCORE wins.
//
// Parameters:
//   TICK_DIV   clock cycles per ball step (2..255)
//   WIN_SCORE  points needed to win (1..15)
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        start / restart game (rising edge)
//   btn_l/btn_r  player buttons (rising edge)
//   lamp[4:0]    lamp drive
//   score_l/r    player scores
//   point_pulse  one-cycle strobe when a point is awarded
//   game_over    a player has reached WIN_SCORE
//   winner       0 = left, 1 = right, valid while game_over
// Optional feature: define LAMP_HANDBALL_SPEEDUP_EN to shorten the step
// period by one cycle on every hit (floor of 2), restored on point or start.
module lamp_handball_ctrl #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned WIN_SCORE = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic [4:0] lamp,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       point_pulse,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned CW = 8;
  localparam int unsigned SW = 4;
  localparam logic [CW-1:0] PERIOD_RST = CW'(TICK_DIV);
  localparam logic [CW-1:0] PERIOD_MIN = CW'(2);
  localparam logic [SW-1:0] WIN_C      = SW'(WIN_SCORE);
  localparam logic [2:0]    POS_L      = 3'd4;
  localparam logic [2:0]    POS_R      = 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_MOVE_L,  // ball travelling toward lamp[4]
    S_MOVE_R,  // ball travelling toward lamp[0]
    S_POINT,
    S_OVER
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          server_q, server_d;   // 0 = left serves, 1 = right serves
  logic [SW-1:0] score_l_q, score_l_d;
  logic [SW-1:0] score_r_q, score_r_d;
  logic          winner_q, winner_d;
  logic          pulse_q, pulse_d;
  logic          over_q, over_d;
  logic [4:0]    lamp_q, lamp_d;
  logic          start_q, btn_l_q, btn_r_q;
  logic          arm_q;

  logic start_e, btn_l_e, btn_r_e;
  logic tick, hit, award_l, award_r;

  // Edges need one registered sample after reset before they can fire.
  assign start_e = arm_q & start & ~start_q;
  assign btn_l_e = arm_q & btn_l & ~btn_l_q;
  assign btn_r_e = arm_q & btn_r & ~btn_r_q;

  assign tick = (cnt_q == (period_q - CW'(1)));

  // Next-state, scoring and output decode.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    server_d  = server_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    pulse_d   = 1'b0;
    hit       = 1'b0;
    award_l   = 1'b0;
    award_r   = 1'b0;
    cnt_d     = '0;
    period_d  = period_q;
    lamp_d    = '0;
    over_d    = 1'b0;

    if (start_e) begin
      state_d   = S_SERVE;
      pos_d     = POS_L;
      server_d  = 1'b0;
      score_l_d = '0;
      score_r_d = '0;
      winner_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_SERVE: begin
          if (!server_q && btn_l_e) begin
            state_d = S_MOVE_R;
          end else if (server_q && btn_r_e) begin
            state_d = S_MOVE_L;
          end
        end
        S_MOVE_R: begin
          if (btn_r_e) begin
            if (pos_q == POS_R) begin
              state_d = S_MOVE_L;
              hit     = 1'b1;
            end else begin
              award_l = 1'b1;
            end
          end else if (tick) begin
            if (pos_q == POS_R) award_l = 1'b1;
            else                pos_d   = pos_q - 3'd1;
          end
        end
        S_MOVE_L: begin
          if (btn_l_e) begin
            if (pos_q == POS_L) begin
              state_d = S_MOVE_R;
              hit     = 1'b1;
            end else begin
              award_r = 1'b1;
            end
          end else if (tick) begin
            if (pos_q == POS_L) award_r = 1'b1;
            else                pos_d   = pos_q + 3'd1;
          end
        end
        S_POINT: begin
          // server_q already names the point loser, so the scorer is its opposite.
          if (tick) begin
            if (server_q) begin
              if (score_l_q == WIN_C) begin
                state_d  = S_OVER;
                winner_d = 1'b0;
              end else begin
                state_d = S_SERVE;
                pos_d   = POS_R;
              end
            end else begin
              if (score_r_q == WIN_C) begin
                state_d  = S_OVER;
                winner_d = 1'b1;
              end else begin
                state_d = S_SERVE;
                pos_d   = POS_L;
              end
            end
          end
        end
        default: ;
      endcase
    end

    if (award_l) begin
      state_d   = S_POINT;
      server_d  = 1'b1;
      pulse_d   = 1'b1;
      score_l_d = (score_l_q < WIN_C) ? score_l_q + SW'(1) : score_l_q;
    end
    if (award_r) begin
      state_d   = S_POINT;
      server_d  = 1'b0;
      pulse_d   = 1'b1;
      score_r_d = (score_r_q < WIN_C) ? score_r_q + SW'(1) : score_r_q;
    end

    // Step timer restarts on any state change, on a hit, and on wrap.
    if ((state_d != state_q) || hit || tick) cnt_d = '0;
    else                                     cnt_d = cnt_q + CW'(1);

`ifdef LAMP_HANDBALL_SPEEDUP_EN
    if (hit) period_d = (period_q > PERIOD_MIN) ? period_q - CW'(1) : PERIOD_MIN;
    if (start_e || (state_d == S_POINT)) period_d = PERIOD_RST;
`else
    period_d = PERIOD_RST;
`endif

    unique case (state_d)
      S_SERVE, S_MOVE_L, S_MOVE_R: lamp_d = 5'b00001 << pos_d;
      S_POINT:                     lamp_d = 5'b11111;
      S_OVER:                      lamp_d = winner_d ? 5'b00001 : 5'b10000;
      default:                     lamp_d = 5'b00000;
    endcase
    over_d = (state_d == S_OVER);
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pos_q     <= POS_L;
      cnt_q     <= '0;
      period_q  <= PERIOD_RST;
      server_q  <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= 1'b0;
      pulse_q   <= 1'b0;
      over_q    <= 1'b0;
      lamp_q    <= '0;
      start_q   <= 1'b0;
      btn_l_q   <= 1'b0;
      btn_r_q   <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      server_q  <= server_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
      pulse_q   <= pulse_d;
      over_q    <= over_d;
      lamp_q    <= lamp_d;
      start_q   <= start;
      btn_l_q   <= btn_l;
      btn_r_q   <= btn_r;
      arm_q     <= 1'b1;
    end
  end

  assign lamp        = lamp_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign point_pulse = pulse_q;
  assign game_over   = over_q;
  assign winner      = winner_q;

endmodule

// File: doc/lamp_handball_ctrl.md
LAMP_HANDBALL_CTRL -- requirements
Module: lamp_handball_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: clock cycles per ball step, legal range 2..255.
REQ-002 SHALL have parameter WIN_SCORE, default 5: points needed to win, legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  start or restart the game.
REQ-006 SHALL have port btn_l  input  1  left player button, guards lamp[4].
REQ-007 SHALL have port btn_r  input  1  right player button, guards lamp[0].
REQ-008 SHALL have port lamp  output  5  lamp drive.
REQ-009 SHALL have port score_l  output  4  left player score.
REQ-010 SHALL have port score_r  output  4  right player score.
REQ-011 SHALL have port point_pulse  output  1  one-cycle strobe when a point is awarded.
REQ-012 SHALL have port game_over  output  1  a player has reached WIN_SCORE.
REQ-013 SHALL have port winner  output  1  0 = left, 1 = right; valid while game_over is 1.

Function
REQ-014 SHALL register btn_l, btn_r and start, and act only on a rising edge of each (0 then 1); a held level SHALL act once.
REQ-015 SHALL implement states IDLE, SERVE, MOVE_L (ball travels toward 4), MOVE_R (ball travels toward 0), POINT and OVER.
REQ-016 SHALL keep ball position pos in 0..4; in SERVE, MOVE_L and MOVE_R, lamp SHALL be one-hot at pos.
REQ-017 lamp SHALL be 5'b00000 in IDLE, 5'b11111 in POINT, and in OVER SHALL light only the winner's end lamp (lamp[4] for left, lamp[0] for right).
REQ-018 The tick counter SHALL count 0..P-1 and tick when it reaches P-1, where P is the current period; it SHALL clear on every state change and on every hit.
REQ-019 A start edge from IDLE SHALL enter SERVE with the left player serving and pos=4.
REQ-020 A start edge in any other state SHALL clear both scores and enter SERVE with left serving, pos=4.
REQ-021 In SERVE, the server's button edge SHALL launch the ball: left serves with pos=4 into MOVE_R, right serves with pos=0 into MOVE_L. The other button SHALL be ignored.
REQ-022 In MOVE_R, each tick with pos>0 SHALL decrement pos.
REQ-023 In MOVE_R, a tick with pos=0 and no btn_r edge in that cycle SHALL be a miss and award the point to the left player.
REQ-024 In MOVE_R, a btn_r edge with pos=0 SHALL be a hit: enter MOVE_L with pos unchanged.
REQ-025 In MOVE_R, a btn_r edge with pos>0 SHALL be an early swing and award the point to the left player.
REQ-026 MOVE_L SHALL mirror REQ-022..025 exactly, with pos=4, increment and btn_l.
REQ-027 During MOVE states, the button of the player the ball is moving away from SHALL be ignored.
REQ-028 A hit in the same cycle as the miss tick SHALL win; the hit takes priority.
REQ-029 A point award SHALL increment the scorer's score and assert point_pulse for exactly 1 cycle, then hold POINT for TICK_DIV cycles.
REQ-030 On leaving POINT, if the scorer's score equals WIN_SCORE the block SHALL enter OVER; otherwise it SHALL enter SERVE with the point loser serving from their own end.
REQ-031 In OVER, game_over=1 and winner SHALL be held, and buttons SHALL be ignored; only a start edge exits OVER.
REQ-032 Scores SHALL never exceed WIN_SCORE.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, lamp=0, both scores 0, point_pulse=0, game_over=0, winner=0, tick counter 0 and all edge registers 0, regardless of clk or the current state.
REQ-034 After reset is released, the first start edge SHALL be detectable only after one registered sample of start=0.

Configuration
REQ-035 With macro LAMP_HANDBALL_SPEEDUP_EN defined, each hit SHALL reduce P by 1, down to a floor of 2; P SHALL return to TICK_DIV on every point and on every start.
REQ-036 Without LAMP_HANDBALL_SPEEDUP_EN, P SHALL equal TICK_DIV at all times.

Verification (TICK_DIV=4, WIN_SCORE=3, macro undefined unless stated)
REQ-037 Reset low mid-rally (pos=2, score_l=1) -> outputs cleared in the same cycle, with no clk edge needed; then start pulse -> lamp=10000.
REQ-038 Left serve -> lamp steps 10000, 01000, 00100, 00010, 00001, each held 4 cycles; btn_r pulse while 00001 -> lamp 00010 four cycles later.
REQ-039 No return at pos 0 -> score_l=1, point_pulse high 1 cycle, lamp=11111 for 4 cycles, then lamp=00001 with right serving.
REQ-040 btn_r pulse while lamp=00100 in MOVE_R -> immediate point to left; btn_l pulse in the same rally -> no effect.
REQ-041 Left wins 3 points -> game_over=1, winner=0, lamp=10000 held; btn presses ignored; start -> scores 0, lamp=10000.
REQ-042 With LAMP_HANDBALL_SPEEDUP_EN: three successive hits -> step periods 4, 3, 2, 2; after a point -> 4.
